// File: rtl/home_alarm_pkg.sv
// Shared definitions for the home alarm controller.
//   - alarm_state_t : panel-visible state encoding (3 bits)
//   - popcount      : number of set bits in a 32-bit vector, used by the
//                     opening-count threshold compare
package home_alarm_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_DISARMED    = 3'd0,
        ST_EXIT_DELAY  = 3'd1,
        ST_ARMED       = 3'd2,
        ST_ENTRY_DELAY = 3'd3,
        ST_ALARM       = 3'd4
    } alarm_state_t;

    // Count of set bits; 6 bits are enough for a 32-bit input.
    function automatic logic [5:0] popcount(input logic [31:0] vec);
        logic [5:0] sum;
        sum = 6'd0;
        for (int i = 0; i < 32; i++) begin
            sum = sum + {5'd0, vec[i]};
        end
        return sum;
    endfunction

endpackage

// File: rtl/alarm_tick_timer.sv
// Tick-driven countdown used for the exit, entry and siren periods.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   load      - load load_val into the counter (wins over a same-cycle tick)
//   load_val  - value to load
//   tick      - 1 Hz strobe; decrements the count while it is above 1
//   clr       - force the count to 0 (highest priority)
//   count     - registered remaining tick count
//   expire    - tick arriving while count==1 (combinational from the register)
module alarm_tick_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             expire
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear, load, or saturating decrement that stops at 1.
    // The owner clears or reloads on expiry, so the count never wraps.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (tick && (count_q > CNT_W'(1))) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign expire = tick && (count_q == CNT_W'(1));

endmodule

// File: rtl/home_alarm_controller.sv
// Home alarm sequencer: arm/disarm, exit delay, entry delay, timed siren.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   tick_1hz     - one-cycle 1 Hz strobe
//   opening      - window/door open bits (already synchronised)
//   arm_req      - one-cycle arm request
//   disarm_req   - one-cycle disarm request
//   armed        - high in every state except DISARMED
//   siren        - high only in ALARM
//   state        - current state encoding for the panel
//   countdown    - ticks remaining in a timed state, else 0
//   alarm_event  - one-cycle pulse on entry to ALARM
module home_alarm_controller
    import home_alarm_pkg::*;
#(
    parameter int N_OPEN     = 4,
    parameter int THRESH     = 3,
    parameter int EXIT_DLY   = 30,
    parameter int ENTRY_DLY  = 15,
    parameter int SIREN_TIME = 180,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_1hz,
    input  logic [N_OPEN-1:0] opening,
    input  logic              arm_req,
    input  logic              disarm_req,
    output logic              armed,
    output logic              siren,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  countdown,
    output logic              alarm_event
);

    alarm_state_t     state_q, state_d;
    logic             armed_q, armed_d;
    logic             siren_q, siren_d;
    logic             alarm_event_q, alarm_event_d;

    logic [31:0]      open_ext_s;
    logic             trigger_s;
    logic             tmr_load_s;
    logic [CNT_W-1:0] tmr_load_val_s;
    logic             tmr_clr_s;
    logic             tmr_expire_s;
    logic [CNT_W-1:0] tmr_count_s;

    assign open_ext_s = 32'(opening);
    assign trigger_s  = (popcount(open_ext_s) >= 6'(THRESH));

    alarm_tick_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_s),
        .load_val (tmr_load_val_s),
        .tick     (tick_1hz),
        .clr      (tmr_clr_s),
        .count    (tmr_count_s),
        .expire   (tmr_expire_s)
    );

    // Next-state and timer control. Disarm beats everything (including a
    // same-cycle arm request while disarmed), then expiry, then trigger,
    // then arm.
    always_comb begin
        state_d        = state_q;
        tmr_load_s     = 1'b0;
        tmr_load_val_s = '0;
        tmr_clr_s      = 1'b0;
        alarm_event_d  = 1'b0;
        if (disarm_req) begin
            state_d   = ST_DISARMED;
            tmr_clr_s = 1'b1;
        end else begin
            case (state_q)
                ST_DISARMED: begin
                    // Refuse to arm while too many openings are open.
                    if (arm_req && !trigger_s) begin
                        state_d        = ST_EXIT_DELAY;
                        tmr_load_s     = 1'b1;
                        tmr_load_val_s = CNT_W'(EXIT_DLY);
                    end else begin
                        state_d = ST_DISARMED;
                    end
                end
                ST_EXIT_DELAY: begin
                    if (tmr_expire_s) begin
                        state_d   = ST_ARMED;
                        tmr_clr_s = 1'b1;
                    end else begin
                        state_d = ST_EXIT_DELAY;
                    end
                end
                ST_ARMED: begin
                    if (trigger_s) begin
                        state_d        = ST_ENTRY_DELAY;
                        tmr_load_s     = 1'b1;
                        tmr_load_val_s = CNT_W'(ENTRY_DLY);
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ENTRY_DELAY: begin
                    // Openings closing again does not cancel the entry delay.
                    if (tmr_expire_s) begin
                        state_d        = ST_ALARM;
                        tmr_load_s     = 1'b1;
                        tmr_load_val_s = CNT_W'(SIREN_TIME);
                        alarm_event_d  = 1'b1;
                    end else begin
                        state_d = ST_ENTRY_DELAY;
                    end
                end
                ST_ALARM: begin
                    // Auto re-arm; a still-open house re-enters entry delay
                    // through the ARMED rule on the following cycle.
                    if (tmr_expire_s) begin
                        state_d   = ST_ARMED;
                        tmr_clr_s = 1'b1;
                    end else begin
                        state_d = ST_ALARM;
                    end
                end
                default: begin
                    // Corrupted encoding: fall back to the safe state.
                    state_d   = ST_DISARMED;
                    tmr_clr_s = 1'b1;
                end
            endcase
        end
        armed_d = (state_d != ST_DISARMED);
        siren_d = (state_d == ST_ALARM);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_DISARMED;
            armed_q       <= 1'b0;
            siren_q       <= 1'b0;
            alarm_event_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            armed_q       <= armed_d;
            siren_q       <= siren_d;
            alarm_event_q <= alarm_event_d;
        end
    end

    assign state       = state_q;
    assign armed       = armed_q;
    assign siren       = siren_q;
    assign alarm_event = alarm_event_q;
    assign countdown   = tmr_count_s;

endmodule

// File: tb/tb_home_alarm_controller.sv
// Scoreboard bench for home_alarm_controller: the driver applies directed
// then random stimulus, a reference model predicts the outputs after each
// clock edge and queues them; the monitor compares on the falling edge.
module tb_home_alarm_controller;

    localparam int N_OPEN     = 4;
    localparam int THRESH     = 3;
    localparam int EXIT_DLY   = 3;
    localparam int ENTRY_DLY  = 2;
    localparam int SIREN_TIME = 4;
    localparam int CNT_W      = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              tick_1hz = 1'b0;
    logic [N_OPEN-1:0] opening = '0;
    logic              arm_req = 1'b0;
    logic              disarm_req = 1'b0;
    logic              armed;
    logic              siren;
    logic [2:0]        state;
    logic [CNT_W-1:0]  countdown;
    logic              alarm_event;

    home_alarm_controller #(
        .N_OPEN(N_OPEN), .THRESH(THRESH), .EXIT_DLY(EXIT_DLY),
        .ENTRY_DLY(ENTRY_DLY), .SIREN_TIME(SIREN_TIME), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .opening(opening),
        .arm_req(arm_req), .disarm_req(disarm_req), .armed(armed),
        .siren(siren), .state(state), .countdown(countdown),
        .alarm_event(alarm_event)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int st;
        int arm;
        int sir;
        int cd;
        int ev;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   edge_cnt = 0;

    // Reference model: mode 0..4 = disarmed, leaving, armed, entering, alarm.
    int m_mode = 0;
    int m_rem  = 0;
    int m_ev   = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_rem  = 0;
        m_ev   = 0;
    endtask

    // One clock of alarm behaviour, written from the user-level rules.
    task automatic model_step(input bit a, input bit d, input bit t, input logic [3:0] op);
        bit open_alarm;
        bit run_out;
        open_alarm = ($countones(op) >= THRESH);
        run_out    = t && (m_rem == 1);
        m_ev       = 0;
        if (d) begin
            m_mode = 0; m_rem = 0;
        end else if (m_mode == 0) begin
            if (a && !open_alarm) begin m_mode = 1; m_rem = EXIT_DLY; end
        end else if (m_mode == 2) begin
            if (open_alarm) begin m_mode = 3; m_rem = ENTRY_DLY; end
        end else if (run_out) begin
            if (m_mode == 3) begin
                m_mode = 4; m_rem = SIREN_TIME; m_ev = 1;
            end else begin
                m_mode = 2; m_rem = 0;
            end
        end else if (t && m_rem > 1) begin
            m_rem = m_rem - 1;
        end
    endtask

    task automatic push_expect();
        exp_t e;
        e.idx = edge_cnt + 1;
        e.st  = m_mode;
        e.arm = (m_mode != 0) ? 1 : 0;
        e.sir = (m_mode == 4) ? 1 : 0;
        e.cd  = m_rem;
        e.ev  = m_ev;
        q.push_back(e);
    endtask

    // Drive one cycle of inputs just after a rising edge and queue the
    // expected outputs for the following edge.
    task automatic drive(input bit a, input bit d, input bit t, input logic [3:0] op);
        @(posedge clk);
        #2;
        arm_req    = a;
        disarm_req = d;
        tick_1hz   = t;
        opening    = op;
        model_step(a, d, t, op);
        push_expect();
    endtask

    task automatic idle(input int n, input logic [3:0] op);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, op);
    endtask

    // Asynchronous reset in the middle of a cycle, checked before any edge.
    task automatic mid_reset();
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_armed", int'(armed), 0);
        chk("async_rst_siren", int'(siren), 0);
        chk("async_rst_countdown", int'(countdown), 0);
        chk("async_rst_event", int'(alarm_event), 0);
        q.delete();
        model_reset();
        arm_req = 1'b0; disarm_req = 1'b0; tick_1hz = 1'b0; opening = '0;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Monitor: compare the queued prediction for the edge just taken.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].idx < edge_cnt) begin
                chk("stale_expectation", q[0].idx, edge_cnt);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].idx == edge_cnt) begin
                exp_t e;
                e = q.pop_front();
                chk("state", int'(state), e.st);
                chk("armed", int'(armed), e.arm);
                chk("siren", int'(siren), e.sir);
                chk("countdown", int'(countdown), e.cd);
                chk("alarm_event", int'(alarm_event), e.ev);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] op_r;
        int         drain;
        // Power-on reset values.
        repeat (2) @(posedge clk);
        #2;
        chk("reset_state", int'(state), 0);
        chk("reset_armed", int'(armed), 0);
        chk("reset_countdown", int'(countdown), 0);
        chk("reset_event", int'(alarm_event), 0);
        rst = 1'b0;
        model_reset();

        // Reset mid exit delay with countdown at 2, then stay disarmed.
        drive(1'b1, 1'b0, 1'b0, 4'b0000);
        drive(1'b0, 1'b0, 1'b1, 4'b0000);
        idle(1, 4'b0000);
        mid_reset();
        idle(3, 4'b0000);

        // Arm, three ticks to ARMED.
        drive(1'b1, 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 4'b0000);
            idle(1, 4'b0000);
        end
        // Trigger with 1011, two ticks into ALARM.
        idle(2, 4'b1011);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b1, 4'b1011);
            idle(1, 4'b1011);
        end
        // Siren period with everything closed, back to ARMED.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 4'b0000);
            idle(1, 4'b0000);
        end
        // Again, but still open at the end of the siren: ARMED then ENTRY.
        idle(1, 4'b0111);
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 1'b1, 4'b0111);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 4'b0111);
        idle(3, 4'b0111);
        drive(1'b0, 1'b1, 1'b0, 4'b0000);
        // Refuse to arm while open.
        drive(1'b1, 1'b0, 1'b0, 4'b1110);
        idle(2, 4'b1110);
        // Arm and disarm together while ARMED.
        drive(1'b1, 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 4'b0000);
        drive(1'b1, 1'b1, 1'b0, 4'b0000);
        idle(1, 4'b0000);
        // Disarm coinciding with the final entry tick.
        drive(1'b1, 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 4'b0000);
        drive(1'b0, 1'b0, 1'b0, 4'b1111);
        drive(1'b0, 1'b0, 1'b1, 4'b0000);
        drive(1'b0, 1'b1, 1'b1, 4'b0000);
        idle(3, 4'b0000);

        // Random traffic, with openings held for stretches.
        op_r = 4'b0000;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) op_r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) begin
                mid_reset();
            end else begin
                drive(($urandom_range(0, 5) == 0), ($urandom_range(0, 39) == 0),
                      ($urandom_range(0, 2) == 0), op_r);
            end
        end
        idle(2, 4'b0000);

        // Let the monitor drain; a leftover prediction counts as a failure.
        drain = 0;
        while (q.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
